// File: rtl/mul_pkg.sv
// Shared definitions for the mul/div issue/retire stage:
// operand width, function codes and the packed op layout.
package mul_pkg;

    localparam int XLEN  = 32;
    localparam int TAG_W = 5;

    typedef enum logic [2:0] {
        MUL    = 3'd0,
        MULH   = 3'd1,
        MULHSU = 3'd2,
        MULHU  = 3'd3,
        DIV    = 3'd4,
        DIVU   = 3'd5,
        REM    = 3'd6,
        REMU   = 3'd7
    } mul_fn_e;

    typedef struct packed {
        logic [2:0]       para;
        logic [XLEN-1:0]  rs0;
        logic [XLEN-1:0]  rs1;
        logic [TAG_W-1:0] tag;
    } mul_op_t;

    // Bits in one packed op entry for a given operand/tag width.
    function automatic int op_width(int xlen, int tag_w);
        return 3 + 2 * xlen + tag_w;
    endfunction

endpackage

// File: rtl/mul_issue_if.sv
// Decode, mul-unit and writeback handshakes of the issue stage.
// slave is the stage's view, master the surrounding pipeline's.
interface mul_issue_if #(
    parameter int XLEN  = 32,
    parameter int TAG_W = 5
);
    logic             op_valid;
    logic             op_ready;
    logic [2:0]       op_para;
    logic [XLEN-1:0]  op_rs0;
    logic [XLEN-1:0]  op_rs1;
    logic [TAG_W-1:0] op_tag;

    logic             mul_initial;
    logic [2:0]       mul_para;
    logic [XLEN-1:0]  mul_rs0;
    logic [XLEN-1:0]  mul_rs1;
    logic             mul_ready;
    logic             mul_finished;
    logic [XLEN-1:0]  mul_data;
    logic             mul_ack;

    logic             wb_valid;
    logic [TAG_W-1:0] wb_tag;
    logic [XLEN-1:0]  wb_data;
    logic             wb_ready;

    modport slave (
        input  op_valid, op_para, op_rs0, op_rs1, op_tag,
        input  mul_ready, mul_finished, mul_data, wb_ready,
        output op_ready, mul_initial, mul_para, mul_rs0, mul_rs1,
        output mul_ack, wb_valid, wb_tag, wb_data
    );

    modport master (
        output op_valid, op_para, op_rs0, op_rs1, op_tag,
        output mul_ready, mul_finished, mul_data, wb_ready,
        input  op_ready, mul_initial, mul_para, mul_rs0, mul_rs1,
        input  mul_ack, wb_valid, wb_tag, wb_data
    );

endinterface

// File: rtl/sync_fifo.sv
// Registered FIFO with synchronous flush; the head entry is read
// straight from storage, so a push is visible one cycle later.
module sync_fifo #(
    parameter  int WIDTH = 8,
    parameter  int DEPTH = 4,
    localparam int AW    = $clog2(DEPTH),
    localparam int CW    = AW + 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             push,
    input  logic             pop,
    input  logic             flush,
    input  logic [WIDTH-1:0] wdata,
    output logic [WIDTH-1:0] rdata,
    output logic [CW-1:0]    count,
    output logic             full,
    output logic             empty
);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic             do_push;
    logic             do_pop;

    assign full    = (count == CW'(DEPTH));
    assign empty   = (count == '0);
    assign do_push = push & ~full & ~flush;
    assign do_pop  = pop & ~empty & ~flush;
    assign rdata   = mem[rd_ptr];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else if (flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + 1'b1;
            if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
            count <= count + CW'(do_push) - CW'(do_pop);
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr] <= wdata;
    end

endmodule

// File: rtl/mul_issue.sv
// Issue/retire stage around the mul/div unit: queues decoded ops,
// starts the unit and tags its results for writeback.
module mul_issue
    import mul_pkg::*;
#(
    parameter int XLEN       = mul_pkg::XLEN,
    parameter int OPQ_DEPTH  = 4,
    parameter int TAGQ_DEPTH = 4,
    parameter int TAG_W      = mul_pkg::TAG_W,
    parameter int CNT_W      = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             clear_pipeline,
    mul_issue_if.slave       bus,
    output logic [CNT_W-1:0] issued_cnt,
    output logic [CNT_W-1:0] retired_cnt,
    output logic             err_orphan
);

    localparam int OP_W = op_width(XLEN, TAG_W);
    localparam int OCW  = $clog2(OPQ_DEPTH) + 1;
    localparam int TCW  = $clog2(TAGQ_DEPTH) + 1;

    logic [OP_W-1:0]  opq_wdata;
    logic [OP_W-1:0]  opq_head;
    logic [OCW-1:0]   opq_count;
    logic             opq_full;
    logic             opq_empty;
    logic [TAG_W-1:0] tagq_head;
    logic [TCW-1:0]   tagq_count;
    logic             tagq_full;
    logic             tagq_empty;

    logic [2:0]       head_para;
    logic [XLEN-1:0]  head_rs0;
    logic [XLEN-1:0]  head_rs1;
    logic [TAG_W-1:0] head_tag;

    logic             push_op;
    logic             issue;
    logic             retire;
    logic             ack;
    logic             unused;

    assign opq_wdata = {bus.op_para, bus.op_rs0, bus.op_rs1, bus.op_tag};
    assign {head_para, head_rs0, head_rs1, head_tag} = opq_head;

    // op_ready is held low while reset is asserted.
    assign bus.op_ready = rst_n & ~clear_pipeline &
                          (opq_count < OCW'(OPQ_DEPTH));
    assign push_op = bus.op_valid & bus.op_ready;

    assign issue = ~opq_empty & bus.mul_ready &
                   ~tagq_full & ~clear_pipeline;

    assign bus.mul_initial = issue;
    assign bus.mul_para    = opq_empty ? '0 : head_para;
    assign bus.mul_rs0     = opq_empty ? '0 : head_rs0;
    assign bus.mul_rs1     = opq_empty ? '0 : head_rs1;

    assign retire = bus.mul_finished & ~tagq_empty & ~clear_pipeline;
    assign ack    = retire & bus.wb_ready;

    assign bus.wb_valid = retire;
    assign bus.wb_tag   = retire ? tagq_head : '0;
    assign bus.wb_data  = retire ? bus.mul_data : '0;
    assign bus.mul_ack  = ack;

    assign unused = ^{opq_full, tagq_count};

    sync_fifo #(
        .WIDTH (OP_W),
        .DEPTH (OPQ_DEPTH)
    ) u_opq (
        .clk   (clk),
        .rst_n (rst_n),
        .push  (push_op),
        .pop   (issue),
        .flush (clear_pipeline),
        .wdata (opq_wdata),
        .rdata (opq_head),
        .count (opq_count),
        .full  (opq_full),
        .empty (opq_empty)
    );

    sync_fifo #(
        .WIDTH (TAG_W),
        .DEPTH (TAGQ_DEPTH)
    ) u_tagq (
        .clk   (clk),
        .rst_n (rst_n),
        .push  (issue),
        .pop   (ack),
        .flush (clear_pipeline),
        .wdata (head_tag),
        .rdata (tagq_head),
        .count (tagq_count),
        .full  (tagq_full),
        .empty (tagq_empty)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            issued_cnt  <= '0;
            retired_cnt <= '0;
            err_orphan  <= 1'b0;
        end else begin
            if (issue) issued_cnt  <= issued_cnt + 1'b1;
            if (ack)   retired_cnt <= retired_cnt + 1'b1;
            if (bus.mul_finished & tagq_empty & ~clear_pipeline)
                err_orphan <= 1'b1;
        end
    end

endmodule
